// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timer derivation shared by uart_tx and uart_rx.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Integer truncation: the receiver runs on exactly the transmitter's bit period.
    function automatic int bit_ticks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int half_ticks(input int clock_freq, input int baud_rate);
        return bit_ticks(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: clearable counter raising tick when it reaches a programmable terminal count.
// Latency: tick is combinational from the count; the count wraps to 0 the cycle after tick.
// Backpressure: none.
module uart_bit_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == term);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Latency: 2-cycle input sync; byte and status pulse appear the cycle after the mid-stop sample.
// Backpressure: none; dout_o holds only until the next frame completes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] dout_o,
    output logic       rx_done_tick_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int BIT_TICKS  = bit_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_TICKS = half_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int TW         = $clog2(BIT_TICKS);
    localparam logic [TW-1:0] BIT_TERM  = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] HALF_TERM = TW'(HALF_TICKS - 1);

    state_t     state_q, state_d;
    logic       rx_meta, rx_s;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       timer_clr, timer_half, tick;
    logic       shift_en, idx_clr, load_dout, done_d, ferr_d, par_bad;

    uart_bit_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_ni (rst_ni),
        .clr    (timer_clr),
        .term   (timer_half ? HALF_TERM : BIT_TERM),
        .tick   (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_en, perr_d;

    assign par_bad = par_q ^ (^shift_q);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q        <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= perr_d;
            if (par_en) par_q <= rx_s;
        end
    end
`else
    assign par_bad      = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        timer_clr  = 1'b0;
        timer_half = 1'b0;
        shift_en   = 1'b0;
        idx_clr    = 1'b0;
        load_dout  = 1'b0;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
        perr_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_clr = 1'b1;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                timer_half = 1'b1;
                if (tick) begin
                    // A start bit that is gone by mid-bit was a glitch.
                    if (!rx_s) begin
                        idx_clr = 1'b1;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_en  = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    load_dout = 1'b1;
                    // Leaving at mid-stop keeps a directly following start bit catchable.
                    if (rx_s) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad;
`endif
                        done_d  = !par_bad;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                timer_clr = 1'b1;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                timer_clr = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state_q        <= S_IDLE;
            shift_q        <= '0;
            bit_idx_q      <= '0;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
            frame_err_o    <= 1'b0;
        end else begin
            rx_meta        <= rx_i;
            rx_s           <= rx_meta;
            state_q        <= state_d;
            rx_done_tick_o <= done_d;
            frame_err_o    <= ferr_d;
            if (idx_clr) begin
                bit_idx_q <= '0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
            if (load_dout) dout_o <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; serial frames are driven and expected
// byte/status pairs are queued, then matched against every status pulse the receiver emits.
module tb_uart_rx;

    localparam int CLK_HZ = 2_000_000;
    localparam int BAUD   = 57_600;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int HALF   = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_FERR = 3'b010;
    localparam logic [2:0] K_PERR = 3'b100;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_ni;
    logic       rx_i;
    logic [7:0] dout_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;
    logic       parity_err_o;

    exp_t exp_q[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .rx_i           (rx_i),
        .dout_o         (dout_o),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o),
        .parity_err_o   (parity_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        rx_i = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back('{kind: K_DONE, data: b});
        send_frame(b, ^b, 1'b1);
    endtask

    // Every status pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_ni && (rx_done_tick_o || frame_err_o || parity_err_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({parity_err_o, frame_err_o, rx_done_tick_o}), 32'(0));
            end else begin
                cur = exp_q.pop_front();
                check("pulse_kind", 32'({parity_err_o, frame_err_o, rx_done_tick_o}), 32'(cur.kind));
                check("dout", 32'(dout_o), 32'(cur.data));
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout_o), 32'(0));
        check("rst_done", 32'(rx_done_tick_o), 32'(0));
        check("rst_ferr", 32'(frame_err_o), 32'(0));
        check("rst_perr", 32'(parity_err_o), 32'(0));
        rst_ni = 1'b1;
        idle(5);

        send_good(8'h55);
        idle(2 * BIT);

        // Back-to-back: next start bit directly follows the stop bit.
        send_good(8'hA3);
        send_good(8'h0F);
        idle(2 * BIT);

        // Low pulse shorter than half a bit is rejected as a glitch.
        rx_i = 1'b0;
        repeat (HALF - 5) @(negedge clk);
        idle(2 * BIT);
        send_good(8'h3C);
        idle(2 * BIT);

        // Bad stop bit followed by a long break: a single frame error.
        exp_q.push_back('{kind: K_FERR, data: 8'hFF});
        send_frame(8'hFF, ^8'hFF, 1'b0);
        rx_i = 1'b0;
        repeat (20 * BIT) @(negedge clk);
        idle(2 * BIT);
        send_good(8'h81);
        idle(2 * BIT);

        // Reset in the middle of data bit 4 of 0xC6.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'hC6 >> i) & 8'h01));
        rx_i = 1'b0;
        repeat (HALF) @(negedge clk);
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        #1;
        check("midrst_dout", 32'(dout_o), 32'(0));
        check("midrst_done", 32'(rx_done_tick_o), 32'(0));
        check("midrst_ferr", 32'(frame_err_o), 32'(0));
        check("midrst_perr", 32'(parity_err_o), 32'(0));
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        idle(2 * BIT);
        send_good(8'h5A);
        idle(2 * BIT);

        if (PAR_EN) begin
            exp_q.push_back('{kind: K_PERR, data: 8'h07});
            send_frame(8'h07, 1'b0, 1'b1);
            idle(2 * BIT);
            send_good(8'h07);
            idle(2 * BIT);
        end

        for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'(0));
        idle(2 * BIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
